// File: rtl/qdiv_seq_pkg.sv
// Shared fixed-point definitions for the qdiv_seq divider: default Q/N widths,
// controller state encoding and iteration-count helper.
package qdiv_seq_pkg;

  localparam int Q_DEFAULT = 8;
  localparam int N_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One quotient bit per magnitude bit of the dividend plus the Q guard shifts.
  function automatic int iter_count(input int n, input int q);
    return n - 1 + q;
  endfunction

endpackage

// File: rtl/qdiv_seq.sv
// Sequential signed-magnitude Q-format divider (restoring, one bit per clock).
// Optional macro QDIV_DIVZERO_EN: short-circuit zero divisors and raise o_dz.
module qdiv_seq
  import qdiv_seq_pkg::*;
#(
  parameter int Q = Q_DEFAULT,
  parameter int N = N_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_quotient,
  output logic         o_complete,
  output logic         o_ovr,
  output logic         o_dz
);

  localparam int ITER = iter_count(N, Q);
  localparam int CW   = $clog2(N + Q);
  localparam int M    = N - 1;
  localparam int DW   = M + Q;

  state_e          state_r, state_s;
  logic            load_s, step_s, finish_s, dz_start_s;
  logic [CW-1:0]   cnt_r;
  logic [DW-1:0]   dvd_r, quo_r;
  logic [N-1:0]    rem_r, diff_s;
  logic [N:0]      rem_shift_s;
  logic [M-1:0]    div_r, mag_s;
  logic            sign_r, ge_s, ovf_s, qsign_s;

  // Next remainder: the shifted value can exceed N bits before the subtract.
  assign rem_shift_s = {rem_r, dvd_r[DW-1]};
  assign ge_s        = (rem_shift_s >= {2'b00, div_r});
  assign diff_s      = rem_shift_s[N-1:0] - {1'b0, div_r};

  assign ovf_s   = |quo_r[DW-1:M];
  assign mag_s   = ovf_s ? {M{1'b1}} : quo_r[M-1:0];
  assign qsign_s = sign_r & (mag_s != {M{1'b0}});

  // Controller state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_s  = state_r;
    load_s   = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          load_s  = 1'b1;
          state_s = dz_start_s ? ST_DONE : ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        step_s = 1'b1;
        if (cnt_r == {CW{1'b0}}) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        finish_s = 1'b1;
        state_s  = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Operand capture and restoring long-division iteration.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r  <= {CW{1'b0}};
      dvd_r  <= {DW{1'b0}};
      quo_r  <= {DW{1'b0}};
      rem_r  <= {N{1'b0}};
      div_r  <= {M{1'b0}};
      sign_r <= 1'b0;
    end else if (load_s) begin
      cnt_r  <= CW'(ITER - 1);
      dvd_r  <= {i_dividend[M-1:0], {Q{1'b0}}};
      quo_r  <= dz_start_s ? {DW{1'b1}} : {DW{1'b0}};
      rem_r  <= {N{1'b0}};
      div_r  <= i_divisor[M-1:0];
      sign_r <= i_dividend[N-1] ^ i_divisor[N-1];
    end else if (step_s) begin
      cnt_r <= cnt_r - CW'(1);
      dvd_r <= {dvd_r[DW-2:0], 1'b0};
      quo_r <= {quo_r[DW-2:0], ge_s};
      rem_r <= ge_s ? diff_s : rem_shift_s[N-1:0];
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Result registers: flags cleared on accept, result published leaving DONE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_quotient <= {N{1'b0}};
      o_complete <= 1'b0;
      o_ovr      <= 1'b0;
    end else if (finish_s) begin
      o_quotient <= {qsign_s, mag_s};
      o_complete <= 1'b1;
      o_ovr      <= ovf_s;
    end else if (load_s) begin
      o_complete <= 1'b0;
      o_ovr      <= 1'b0;
    end else begin
      o_complete <= 1'b0;
    end
  end

`ifdef QDIV_DIVZERO_EN
  logic dz_r;

  assign dz_start_s = (i_divisor[M-1:0] == {M{1'b0}});

  // Divide-by-zero flag follows the operation from accept to publication.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dz_r <= 1'b0;
      o_dz <= 1'b0;
    end else if (load_s) begin
      dz_r <= dz_start_s;
      o_dz <= 1'b0;
    end else if (finish_s) begin
      o_dz <= dz_r;
    end else begin
      o_dz <= o_dz;
    end
  end
`else
  assign dz_start_s = 1'b0;
  assign o_dz       = 1'b0;
`endif

endmodule

// File: tb/tb_qdiv_seq.sv
// Self-checking bench for qdiv_seq: directed vector table, hand-written
// multi-cycle sequences and randomized operands against a plain-arithmetic model.
module tb_qdiv_seq;

  localparam int N    = 16;
  localparam int Q    = 8;
  localparam int ITER = N - 1 + Q;
`ifdef QDIV_DIVZERO_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif
  localparam int LAT    = ITER + 1;
  localparam int LAT_DZ = DZ_EN ? 1 : ITER + 1;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_start;
  logic [N-1:0] i_dividend, i_divisor;
  logic [N-1:0] o_quotient;
  logic         o_complete, o_ovr, o_dz;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic         ovr;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[15];

  qdiv_seq dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_quotient (o_quotient),
    .o_complete (o_complete),
    .o_ovr      (o_ovr),
    .o_dz       (o_dz)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: quotient magnitude is (|a| * 2^Q) / |b| in plain integer arithmetic.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] q, output logic ovr,
                                output logic dz, output int lat);
    logic [63:0] am, bm, raw, mag;
    am = 64'(a[N-2:0]);
    bm = 64'(b[N-2:0]);
    if (bm == 64'd0) raw = (64'd1 << (N - 1 + Q)) - 64'd1;
    else             raw = (am << Q) / bm;
    ovr = (raw >= (64'd1 << (N - 1)));
    mag = ovr ? ((64'd1 << (N - 1)) - 64'd1) : raw;
    q   = {(mag != 64'd0) ? (a[N-1] ^ b[N-1]) : 1'b0, mag[N-2:0]};
    dz  = DZ_EN && (bm == 64'd0);
    lat = dz ? 1 : ITER + 1;
  endfunction

  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge i_clk);
    i_start    = 1'b1;
    i_dividend = a;
    i_divisor  = b;
    @(posedge i_clk);
    #1;
    i_start    = 1'b0;
    i_dividend = N'($urandom);
    i_divisor  = N'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge i_clk);
      #1;
      if (o_complete) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] eq, input logic eovr, input logic edz,
                         input int elat);
    int lat;
    start_op(a, b);
    check($sformatf("%s a=%h b=%h ovr_clear", name, a, b), 32'(o_ovr), 32'd0);
    check($sformatf("%s a=%h b=%h cmpl_low", name, a, b), 32'(o_complete), 32'd0);
    wait_done(lat);
    check($sformatf("%s a=%h b=%h latency", name, a, b), 32'(lat), 32'(elat));
    check($sformatf("%s a=%h b=%h quotient", name, a, b), 32'(o_quotient), 32'(eq));
    check($sformatf("%s a=%h b=%h ovr", name, a, b), 32'(o_ovr), 32'(eovr));
    check($sformatf("%s a=%h b=%h dz", name, a, b), 32'(o_dz), 32'(edz));
  endtask

  initial begin
    logic [N-1:0] ra, rb, eq;
    logic         eovr, edz;
    int           elat, lat, seen;

    vecs[0]  = '{16'h0180, 16'h0080, 16'h0300, 1'b0, 1'b0, LAT};
    vecs[1]  = '{16'h8180, 16'h0080, 16'h8300, 1'b0, 1'b0, LAT};
    vecs[2]  = '{16'h8180, 16'h8080, 16'h0300, 1'b0, 1'b0, LAT};
    vecs[3]  = '{16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, LAT};
    vecs[4]  = '{16'h8000, 16'h0080, 16'h0000, 1'b0, 1'b0, LAT};
    vecs[5]  = '{16'h7F00, 16'h0080, 16'h7FFF, 1'b1, 1'b0, LAT};
    vecs[6]  = '{16'hFF00, 16'h0080, 16'hFFFF, 1'b1, 1'b0, LAT};
    vecs[7]  = '{16'h0100, 16'h0000, 16'h7FFF, 1'b1, DZ_EN, LAT_DZ};
    vecs[8]  = '{16'h8100, 16'h0000, 16'hFFFF, 1'b1, DZ_EN, LAT_DZ};
    vecs[9]  = '{16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b0, LAT};
    vecs[10] = '{16'h8001, 16'h7FFF, 16'h0000, 1'b0, 1'b0, LAT};
    vecs[11] = '{16'h7FFF, 16'h0100, 16'h7FFF, 1'b0, 1'b0, LAT};
    vecs[12] = '{16'h7FFF, 16'h0101, 16'h7F7F, 1'b0, 1'b0, LAT};
    vecs[13] = '{16'h4000, 16'h0100, 16'h4000, 1'b0, 1'b0, LAT};
    vecs[14] = '{16'h4000, 16'h00FF, 16'h4040, 1'b0, 1'b0, LAT};

    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_dividend = {N{1'b0}};
    i_divisor  = {N{1'b0}};
    repeat (2) @(posedge i_clk);
    #1;
    check("reset quotient", 32'(o_quotient), 32'd0);
    check("reset complete", 32'(o_complete), 32'd0);
    check("reset ovr", 32'(o_ovr), 32'd0);
    check("reset dz", 32'(o_dz), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q,
              vecs[i].ovr, vecs[i].dz, vecs[i].lat);
    end

    // A start request during BUSY must not disturb the running division.
    start_op(16'h0180, 16'h0080);
    repeat (4) @(negedge i_clk);
    i_start    = 1'b1;
    i_dividend = 16'h0100;
    i_divisor  = 16'h0300;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    wait_done(lat);
    check("busy_start latency", 32'(lat + 4), 32'(LAT));
    check("busy_start quotient", 32'(o_quotient), 32'h0300);
    check("busy_start ovr", 32'(o_ovr), 32'd0);

    // Reset during BUSY aborts; the aborted overflow result must never appear.
    start_op(16'h7F00, 16'h0080);
    repeat (10) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    check("midrst quotient", 32'(o_quotient), 32'd0);
    check("midrst complete", 32'(o_complete), 32'd0);
    check("midrst ovr", 32'(o_ovr), 32'd0);
    check("midrst dz", 32'(o_dz), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge i_clk);
      #1;
      if (o_complete || o_ovr) seen = 1;
    end
    check("midrst idle_quiet", 32'(seen), 32'd0);
    run_vec("after_rst", 16'h0180, 16'h0080, 16'h0300, 1'b0, 1'b0, LAT);

    for (int i = 0; i < 60; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = rb & 16'h8000;
        1, 2:    rb = rb & 16'h80FF;
        3:       ra = ra & 16'h80FF;
        default: rb = rb;
      endcase
      model(ra, rb, eq, eovr, edz, elat);
      run_vec($sformatf("rand%0d", i), ra, rb, eq, eovr, edz, elat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
